fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes; lane 0 is oldest in a bundle.
REQ-002 Parameter STAGES, default 3, number of tracked post-issue stages (0=EX, 1=MEM, 2=WB).
REQ-003 Parameter AW, default 5, register address width.
REQ-004 Derived constant SELW = clog2(STAGES*LANES+1), select width.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 iss_valid  in  LANES  lane l holds a valid instruction in ID.
REQ-008 iss_rd / iss_wen / iss_load  in  LANES*AW / LANES / LANES  destination, write enable, load flag per lane.
REQ-009 src_rs / src_ren  in  LANES*2*AW / LANES*2  two source addresses and read enables per lane.
REQ-010 hold  in  1  external freeze of the whole pipeline (e.g. LSU busy).
REQ-011 flush  in  1  kill the bundle currently in ID (branch resolved in EX).
REQ-012 src_sel  out  LANES*2*SELW  bypass select per source; 0 = register file, k = s*LANES+l+1 = stage s, lane l.
REQ-013 lu_stall  out  1  load-use stall request to ID.
REQ-014 lu_count  out  32  saturating count of cycles with lu_stall=1 and hold=0.

Function
REQ-015 Tag pipeline SHALL hold, per stage and lane, {valid, rd, load}.
REQ-016 Producer match SHALL require: entry valid, rd == source, rd != 0, and the source's src_ren = 1.
REQ-017 src_sel SHALL pick the youngest matching producer: lowest stage first; within a stage, the highest lane first.
REQ-018 src_sel SHALL be 0 when the source is unread, or when its lane's iss_valid = 0, or when there is no match.
REQ-019 lu_stall SHALL be 1 when any valid-lane source's selected producer is in stage 0 with load = 1.
REQ-020 src_sel is combinational from inputs and registered tags; lu_stall likewise; there SHALL be no added latency.
REQ-021 Advance (hold=0) SHALL shift stage s into s+1; stage STAGES-1 SHALL retire.
REQ-022 On advance, stage 0 SHALL load iss_* with valid = iss_valid & iss_wen, except when lu_stall=1 or flush=1.
REQ-023 When lu_stall=1 or flush=1 on advance, stage 0 SHALL load a bubble (all valid 0).
REQ-024 hold=1 SHALL freeze all stages and lu_count; hold dominates flush and lu_stall.
REQ-025 Same-bundle lane0-to-lane1 dependence is resolved by decode; it SHALL NOT be matched here.
REQ-026 lu_count SHALL increment by 1 per qualifying cycle and saturate at 0xFFFFFFFF.

Reset
REQ-027 rst=1 SHALL clear every valid bit and set lu_count to 0 at the next edge, overriding hold and flush.
REQ-028 Consequently, in the cycle after reset, src_sel = 0 on all sources and lu_stall = 0.
REQ-029 Reset asserted mid-stall SHALL drop lu_stall in the following cycle; no entry survives.

Structure
REQ-030 Shared package core_pkg SHALL hold BYPASS_NONE=0, the select-index formula function, and the tag-entry struct.
REQ-031 One sub-module, bypass_match, SHALL implement the per-source priority match, instantiated LANES*2 times.
REQ-032 Parameter checks (LANES>=1, STAGES>=2) SHALL be elaboration-time errors.

Verification
REQ-033 Issue lane0 rd=5 ALU; next cycle lane1 rs1=5 -> src_sel(lane1,rs1) = 1 (stage 0, lane 0), lu_stall=0.
REQ-034 Bundle lane0 rd=7, lane1 rd=7; next cycle lane0 rs2=7 -> select = 2 (stage 0, lane 1 wins).
REQ-035 Load lane0 rd=9; next cycle lane0 rs1=9 -> lu_stall=1 and a bubble is inserted; following cycle select = 3 (stage 1, lane 0), lu_stall=0, lu_count=1.
REQ-036 Issue rd=0 with wen=1, then read rs1=0 -> select = 0.
REQ-037 hold=1 for 3 cycles with rd=4 in stage 1 -> select for rs=4 stays 3; after release it becomes 5, then 0.
REQ-038 flush with lane0 rd=6 in ID -> next cycle rs=6 select = 0; rst during lu_stall -> lu_stall=0 and lu_count=0 the next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the forwarding scoreboard: tag entries and
// the bypass select encoding.
package core_pkg;

    localparam int BYPASS_NONE = 0;
    // Tags store rd zero-extended to this width so one struct serves any AW up to it.
    localparam int TAG_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic              load;
    } tag_t;

    function automatic int sel_index(input int stage, input int lane, input int lanes);
        return stage * lanes + lane + 1;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/bypass bundle between the ID stage and the forwarding scoreboard.
interface fwd_scoreboard_if #(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int AW     = 5
);
    localparam int SELW = $clog2(STAGES * LANES + 1);

    logic [LANES-1:0]                 iss_valid;
    logic [LANES-1:0][AW-1:0]         iss_rd;
    logic [LANES-1:0]                 iss_wen;
    logic [LANES-1:0]                 iss_load;
    logic [LANES-1:0][1:0][AW-1:0]    src_rs;
    logic [LANES-1:0][1:0]            src_ren;
    logic                             hold;
    logic                             flush;
    logic [LANES-1:0][1:0][SELW-1:0]  src_sel;
    logic                             lu_stall;
    logic [31:0]                      lu_count;

    modport master (
        output iss_valid, iss_rd, iss_wen, iss_load, src_rs, src_ren, hold, flush,
        input  src_sel, lu_stall, lu_count
    );

    modport slave (
        input  iss_valid, iss_rd, iss_wen, iss_load, src_rs, src_ren, hold, flush,
        output src_sel, lu_stall, lu_count
    );
endinterface

// File: rtl/bypass_match.sv
// Per-source producer search over the tag pipeline; returns the youngest
// matching producer and whether it is a load still in EX.
module bypass_match
    import core_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int SELW   = 3
) (
    input  tag_t [STAGES-1:0][LANES-1:0] tags,
    input  logic [AW-1:0]                rs,
    input  logic                         ren,
    input  logic                         lane_valid,
    output logic [SELW-1:0]              sel,
    output logic                         load_hit
);

    logic [TAG_AW-1:0] rs_ext;
    assign rs_ext = TAG_AW'(rs);

    // Walk oldest to youngest so the last hit (lowest stage, highest lane) wins.
    always_comb begin
        sel      = SELW'(BYPASS_NONE);
        load_hit = 1'b0;
        if (lane_valid && ren && (rs_ext != '0)) begin
            for (int s = STAGES - 1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (tags[s][l].valid && (tags[s][l].rd == rs_ext)) begin
                        sel      = SELW'(sel_index(s, l, LANES));
                        load_hit = (s == 0) && tags[s][l].load;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks destination tags through EX/MEM/WB, drives
// per-source bypass selects and the load-use stall.
module fwd_scoreboard
    import core_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int AW     = 5
) (
    input logic              clk,
    input logic              rst,
    fwd_scoreboard_if.slave  bus
);

    localparam int SELW = $clog2(STAGES * LANES + 1);

    if (LANES < 1) begin : g_bad_lanes
        $error("fwd_scoreboard: LANES must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("fwd_scoreboard: STAGES must be >= 2");
    end
    if (AW > TAG_AW) begin : g_bad_aw
        $error("fwd_scoreboard: AW exceeds tag rd width");
    end

    tag_t [STAGES-1:0][LANES-1:0]    tags;
    tag_t [LANES-1:0]                issue_tags;
    logic [LANES-1:0][1:0][SELW-1:0] sel;
    logic [LANES-1:0][1:0]           load_hit;
    logic                            lu_stall;
    logic [31:0]                     lu_count;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign issue_tags[l].valid = bus.iss_valid[l] & bus.iss_wen[l];
        assign issue_tags[l].rd    = TAG_AW'(bus.iss_rd[l]);
        assign issue_tags[l].load  = bus.iss_load[l];

        for (genvar j = 0; j < 2; j++) begin : g_src
            bypass_match #(
                .LANES  (LANES),
                .STAGES (STAGES),
                .AW     (AW),
                .SELW   (SELW)
            ) u_match (
                .tags       (tags),
                .rs         (bus.src_rs[l][j]),
                .ren        (bus.src_ren[l][j]),
                .lane_valid (bus.iss_valid[l]),
                .sel        (sel[l][j]),
                .load_hit   (load_hit[l][j])
            );
        end
    end

    assign lu_stall     = |load_hit;
    assign bus.src_sel  = sel;
    assign bus.lu_stall = lu_stall;
    assign bus.lu_count = lu_count;

    // A stalled or flushed bundle enters EX as a bubble; hold freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            tags     <= '0;
            lu_count <= '0;
        end else if (!bus.hold) begin
            for (int s = STAGES - 1; s > 0; s--) begin
                tags[s] <= tags[s-1];
            end
            tags[0] <= (lu_stall || bus.flush) ? '0 : issue_tags;
            if (lu_stall && (lu_count != 32'hFFFF_FFFF)) begin
                lu_count <= lu_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scenario bench for fwd_scoreboard: expectations are queued as stimulus is
// applied, paired with sampled outputs, and compared at the end of each task.
module tb_fwd_scoreboard;

    localparam int LANES  = 2;
    localparam int STAGES = 3;
    localparam int AW     = 5;

    typedef struct {
        int          lane;
        int          src;
        logic [2:0]  sel;
        logic        stall;
        logic [31:0] cnt;
    } rec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    checks   = 0;
    int    failures = 0;
    string tname;
    rec_t  exp_q[$];
    rec_t  obs_q[$];

    fwd_scoreboard_if #(.LANES(LANES), .STAGES(STAGES), .AW(AW)) bus ();

    fwd_scoreboard #(.LANES(LANES), .STAGES(STAGES), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.iss_valid = '0;
        bus.iss_rd    = '0;
        bus.iss_wen   = '0;
        bus.iss_load  = '0;
        bus.src_rs    = '0;
        bus.src_ren   = '0;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int l, input int rd, input bit ld);
        bus.iss_valid[l] = 1'b1;
        bus.iss_wen[l]   = 1'b1;
        bus.iss_rd[l]    = 5'(rd);
        bus.iss_load[l]  = ld;
    endtask

    task automatic rd_src(input int l, input int j, input int rs);
        bus.iss_valid[l]  = 1'b1;
        bus.src_ren[l][j] = 1'b1;
        bus.src_rs[l][j]  = 5'(rs);
    endtask

    // Queue the expected result and snapshot what the DUT shows this cycle.
    task automatic chk(input int l, input int j, input int sel, input bit stall, input int unsigned cnt);
        rec_t e;
        rec_t o;
        #1;
        e.lane = l; e.src = j; e.sel = 3'(sel); e.stall = stall; e.cnt = cnt;
        o.lane = l; o.src = j; o.sel = bus.src_sel[l][j]; o.stall = bus.lu_stall; o.cnt = bus.lu_count;
        exp_q.push_back(e);
        obs_q.push_back(o);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        rec_t e, o;
        tname = "test_reset";
        do_reset();
        wr(0, 3, 1'b0);
        wr(1, 3, 1'b1);
        next();
        rd_src(0, 0, 3);
        chk(0, 0, 2, 1'b1, 0);
        rst = 1'b1; bus.hold = 1'b1; bus.flush = 1'b1;
        next();
        rst = 1'b0;
        for (int l = 0; l < LANES; l++)
            for (int j = 0; j < 2; j++) rd_src(l, j, 3);
        for (int l = 0; l < LANES; l++)
            for (int j = 0; j < 2; j++) chk(l, j, 0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_alu_fwd();
        rec_t e, o;
        tname = "test_alu_fwd";
        do_reset();
        wr(0, 5, 1'b0);
        next();
        rd_src(1, 0, 5);
        chk(1, 0, 1, 1'b0, 0);
        bus.iss_valid[0] = 1'b1;
        bus.src_rs[0][1] = 5'd5;
        chk(0, 1, 0, 1'b0, 0);
        next();
        bus.src_ren[1][0] = 1'b1;
        bus.src_rs[1][0]  = 5'd5;
        chk(1, 0, 0, 1'b0, 0);
        rd_src(0, 0, 5);
        chk(0, 0, 3, 1'b0, 0);
        next();
        rd_src(0, 1, 5);
        chk(0, 1, 5, 1'b0, 0);
        next();
        rd_src(0, 1, 5);
        chk(0, 1, 0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_priority();
        rec_t e, o;
        tname = "test_priority";
        do_reset();
        wr(0, 7, 1'b0);
        wr(1, 7, 1'b0);
        next();
        rd_src(0, 1, 7);
        wr(0, 7, 1'b0);
        chk(0, 1, 2, 1'b0, 0);
        next();
        rd_src(1, 0, 7);
        chk(1, 0, 1, 1'b0, 0);
        wr(0, 8, 1'b0);
        rd_src(1, 1, 8);
        chk(1, 1, 0, 1'b0, 0);
        next();
        rd_src(1, 1, 8);
        chk(1, 1, 1, 1'b0, 0);
        rd_src(0, 0, 7);
        chk(0, 0, 3, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_load_use();
        rec_t e, o;
        tname = "test_load_use";
        do_reset();
        wr(0, 9, 1'b1);
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 1, 1'b1, 0);
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 3, 1'b0, 1);
        next();
        wr(0, 9, 1'b1);
        wr(1, 9, 1'b0);
        next();
        rd_src(0, 1, 9);
        chk(0, 1, 2, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_zero();
        rec_t e, o;
        tname = "test_zero";
        do_reset();
        wr(0, 0, 1'b0);
        wr(1, 0, 1'b1);
        next();
        rd_src(0, 0, 0);
        rd_src(1, 1, 0);
        chk(0, 0, 0, 1'b0, 0);
        chk(1, 1, 0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_hold();
        rec_t e, o;
        tname = "test_hold";
        do_reset();
        wr(0, 4, 1'b0);
        next();
        for (int i = 0; i < 3; i++) begin
            next();
            bus.hold = 1'b1;
            bus.flush = 1'b1;
            wr(1, 4, 1'b1);
            rd_src(0, 0, 4);
            chk(0, 0, 3, 1'b0, 0);
        end
        next();
        rd_src(0, 0, 4);
        chk(0, 0, 3, 1'b0, 0);
        next();
        rd_src(0, 0, 4);
        chk(0, 0, 5, 1'b0, 0);
        next();
        rd_src(0, 0, 4);
        chk(0, 0, 0, 1'b0, 0);
        wr(0, 9, 1'b1);
        for (int i = 0; i < 2; i++) begin
            next();
            bus.hold = 1'b1;
            rd_src(0, 0, 9);
            chk(0, 0, 1, 1'b1, 0);
        end
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 1, 1'b1, 0);
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 3, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_flush();
        rec_t e, o;
        tname = "test_flush";
        do_reset();
        wr(1, 6, 1'b0);
        next();
        wr(0, 6, 1'b0);
        bus.flush = 1'b1;
        rd_src(1, 0, 6);
        chk(1, 0, 2, 1'b0, 0);
        next();
        rd_src(0, 0, 6);
        chk(0, 0, 4, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    task automatic test_reset_stall();
        rec_t e, o;
        tname = "test_reset_stall";
        do_reset();
        wr(0, 9, 1'b1);
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 1, 1'b1, 0);
        next();
        wr(0, 9, 1'b1);
        chk(0, 1, 0, 1'b0, 1);
        next();
        rd_src(0, 0, 9);
        chk(0, 0, 1, 1'b1, 1);
        rst = 1'b1; bus.hold = 1'b1; bus.flush = 1'b1;
        next();
        rst = 1'b0;
        rd_src(0, 0, 9);
        chk(0, 0, 0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.sel !== e.sel) begin failures++; $display("FAIL %s sel[%0d][%0d] got=%0d want=%0d", tname, e.lane, e.src, o.sel, e.sel); end
            checks++; if (o.stall !== e.stall) begin failures++; $display("FAIL %s lu_stall got=%0b want=%0b", tname, o.stall, e.stall); end
            checks++; if (o.cnt !== e.cnt) begin failures++; $display("FAIL %s lu_count got=%0d want=%0d", tname, o.cnt, e.cnt); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_fwd();
        test_priority();
        test_load_use();
        test_zero();
        test_hold();
        test_flush();
        test_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
